// File: rtl/rle_expander_if.sv
// Record input and expanded-sample output handshakes of the RLE expander.
interface rle_expander_if;
  logic       rec_valid;
  logic       rec_ready;
  logic [7:0] rec_data;
  logic [7:0] rec_cnt;
  logic       rec_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  // Expander side: consumes records, produces samples.
  modport slave (
    input  rec_valid, rec_data, rec_cnt, rec_last, out_ready,
    output rec_ready, out_valid, out_data, out_last
  );

  // Environment side: produces records, consumes samples.
  modport master (
    output rec_valid, rec_data, rec_cnt, rec_last, out_ready,
    input  rec_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/rle_expander.sv
// Expands {sample, run count} records into one sample per handshake, holding
// an active run plus one pending record so consecutive runs have no bubble.
module rle_expander #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             rle_en,
  rle_expander_if.slave    bus,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             done
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RCNT_W = 8;

  typedef enum logic [1:0] {S_EMPTY, S_RUN, S_FULL} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RCNT_W-1:0] rem;
    logic              last;
  } run_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RCNT_W-1:0] cnt;
    logic              rle;
    logic              last;
  } pend_t;

  state_t state_q, state_d;
  run_t   run_q, run_d;
  pend_t  pend_q, pend_d;
  pend_t  in_rec_c;
  logic   out_valid_q, out_valid_d;
  logic   out_last_q, out_last_d;
  logic   accept_c, consume_c, run_free_c;

  // RLE mode is latched per record here, so later RLE_EN changes cannot
  // affect runs already stored.
  function automatic run_t load_run(input pend_t r);
    run_t v;
    v.data = r.data;
    v.rem  = r.rle ? r.cnt : RCNT_W'(0);
    v.last = r.last;
    return v;
  endfunction

  // Pending slot occupied exactly in S_FULL; ready never depends on out_ready.
  assign bus.rec_ready = (state_q != S_FULL) && !rst && !clr;
  assign accept_c      = bus.rec_valid && bus.rec_ready;
  assign consume_c     = out_valid_q && bus.out_ready;
  assign run_free_c    = (state_q == S_EMPTY) || (consume_c && (run_q.rem == RCNT_W'(0)));
  assign in_rec_c      = {bus.rec_data, bus.rec_cnt, rle_en, bus.rec_last};

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = run_q.data;
  assign bus.out_last  = out_last_q;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    pend_d  = pend_q;
    case (state_q)
      S_EMPTY: begin
        if (accept_c) begin
          run_d   = load_run(in_rec_c);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (run_free_c) begin
          if (accept_c) run_d = load_run(in_rec_c);
          else          state_d = S_EMPTY;
        end else begin
          if (consume_c) run_d.rem = RCNT_W'(run_q.rem - RCNT_W'(1));
          if (accept_c) begin
            pend_d  = in_rec_c;
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (run_free_c) begin
          run_d   = load_run(pend_q);
          state_d = S_RUN;
        end else if (consume_c) begin
          run_d.rem = RCNT_W'(run_q.rem - RCNT_W'(1));
        end
      end
      default: state_d = S_EMPTY;
    endcase
    out_valid_d = (state_d != S_EMPTY);
    out_last_d  = out_valid_d && run_d.last && (run_d.rem == RCNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q     <= S_EMPTY;
      run_q       <= '0;
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sample_cnt  <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done        <= consume_c && out_last_q;
      if (consume_c && (sample_cnt != {CNT_W{1'b1}}))
        sample_cnt <= CNT_W'(sample_cnt + CNT_W'(1));
    end
  end

endmodule

// File: tb/tb_rle_expander.sv
// Directed and table-driven checks of rle_expander against hand-computed expansions.
module tb_rle_expander;

  typedef struct {
    int         grp;
    logic       rle;
    logic [7:0] data;
    logic [7:0] cnt;
    logic       last;
    int         exp_n;
    int         exp_total;
  } vec_t;

  typedef struct {
    logic       rle;
    logic [7:0] data;
    logic [7:0] cnt;
    logic       last;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } smp_t;

  logic        clk = 1'b1;
  logic        rst, clr, rle_en;
  logic [23:0] sample_cnt;
  logic        done;
  logic        rst4, clr4, rle4;
  logic [3:0]  sample_cnt4;
  logic        done4;

  rle_expander_if tif();
  rle_expander_if tif4();

  rle_expander #(.CNT_W(24)) dut (
    .clk(clk), .rst(rst), .clr(clr), .rle_en(rle_en),
    .bus(tif), .sample_cnt(sample_cnt), .done(done)
  );

  rle_expander #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .clr(clr4), .rle_en(rle4),
    .bus(tif4), .sample_cnt(sample_cnt4), .done(done4)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  rec_t        src_q[$];
  smp_t        exp_q[$];
  logic [23:0] exp_cnt;
  logic        done_exp, prev_stall, prev_last;
  logic [7:0]  prev_data;
  bit          started, saw_block;
  int          gaps, blk, max_blk;
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One cycle: check outputs, record handshakes, advance to the next falling edge.
  task automatic tick();
    bit   acc, cons;
    smp_t e;
    #1;
    if (!rst && !clr) begin
      chk("done", done, done_exp);
      if (prev_stall) begin
        chk("stall_valid", tif.out_valid, 1);
        chk("stall_data", tif.out_data, prev_data);
        chk("stall_last", tif.out_last, prev_last);
      end
    end
    acc  = tif.rec_valid && tif.rec_ready;
    cons = tif.out_valid && tif.out_ready && !rst && !clr;
    if (tif.rec_valid && !tif.rec_ready && !rst && !clr) begin
      blk++;
      saw_block = 1;
      if (blk > max_blk) max_blk = blk;
    end else blk = 0;
    if (started && !tif.out_valid && exp_q.size() != 0) gaps++;
    if (cons) begin
      started = 1;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL extra_sample: got %0h expected none at %0t", tif.out_data, $time);
      end else begin
        n_chk--;
        e = exp_q.pop_front();
        chk("out_data", tif.out_data, e.data);
        chk("out_last", tif.out_last, e.last);
      end
      if (exp_cnt != 24'hFFFFFF) exp_cnt++;
    end
    done_exp   = cons && tif.out_last;
    prev_stall = tif.out_valid && !tif.out_ready && !rst && !clr;
    prev_data  = tif.out_data;
    prev_last  = tif.out_last;
    if (acc && src_q.size() != 0) void'(src_q.pop_front());
    @(negedge clk);
  endtask

  // Feed queued records and drain expected samples within a cycle budget.
  task automatic run_stream(input bit rnd, input int budget);
    int   cyc;
    rec_t r;
    cyc = 0; started = 0; gaps = 0; blk = 0; max_blk = 0; saw_block = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      if (src_q.size() != 0) begin
        r = src_q[0];
        tif.rec_valid = 1'b1;
        tif.rec_data  = r.data;
        tif.rec_cnt   = r.cnt;
        tif.rec_last  = r.last;
        rle_en        = r.rle;
      end else tif.rec_valid = 1'b0;
      tif.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
    end
    chk("stream_drained", src_q.size() + exp_q.size(), 0);
    tif.rec_valid = 1'b0;
    tif.out_ready = 1'b1;
    tick();
    tick();
    chk("idle_out_valid", tif.out_valid, 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tif.out_ready = 1'b0;
    tif.rec_valid = 1'b1;
    tif.rec_data  = 8'hEE;
    tif.rec_cnt   = 8'd7;
    tif.rec_last  = 1'b1;
    #1 chk("rec_ready_in_clr", tif.rec_ready, 0);
    tick();
    clr = 1'b0;
    tif.rec_valid = 1'b0;
    src_q.delete();
    exp_q.delete();
    exp_cnt = '0;
    #1;
    chk("clr_out_valid", tif.out_valid, 0);
    chk("clr_sample_cnt", sample_cnt, 0);
    chk("clr_rec_ready", tif.rec_ready, 1);
    chk("clr_done", done, 0);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l);
    smp_t s;
    s.data = d;
    s.last = l;
    exp_q.push_back(s);
  endtask

  initial begin
    rec_t r;
    int   tot;
    vecs[0] = '{0, 1'b1, 8'hA5, 8'd3, 1'b1, 4, 4};
    vecs[1] = '{1, 1'b1, 8'h01, 8'd0, 1'b0, 1, 5};
    vecs[2] = '{1, 1'b1, 8'h02, 8'd2, 1'b0, 3, 5};
    vecs[3] = '{1, 1'b1, 8'h03, 8'd0, 1'b1, 1, 5};
    vecs[4] = '{2, 1'b0, 8'h01, 8'd0, 1'b0, 1, 3};
    vecs[5] = '{2, 1'b0, 8'h02, 8'd2, 1'b0, 1, 3};
    vecs[6] = '{2, 1'b0, 8'h03, 8'd0, 1'b1, 1, 3};

    rst = 1'b1; clr = 1'b0; rle_en = 1'b1;
    tif.rec_valid = 1'b0; tif.rec_data = '0; tif.rec_cnt = '0; tif.rec_last = 1'b0;
    tif.out_ready = 1'b0;
    rst4 = 1'b1; clr4 = 1'b0; rle4 = 1'b1;
    tif4.rec_valid = 1'b0; tif4.rec_data = '0; tif4.rec_cnt = '0; tif4.rec_last = 1'b0;
    tif4.out_ready = 1'b0;
    exp_cnt = '0; done_exp = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;

    @(negedge clk);
    tick();
    #1 chk("rec_ready_in_rst", tif.rec_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", tif.out_valid, 0);
    chk("rst_out_data", tif.out_data, 0);
    chk("rst_out_last", tif.out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_rec_ready", tif.rec_ready, 1);

    // Table-driven groups with full-rate output.
    for (int g = 0; g < 3; g++) begin
      do_clr();
      tot = 0;
      for (int i = 0; i < 7; i++) begin
        if (vecs[i].grp == g) begin
          r.rle = vecs[i].rle; r.data = vecs[i].data;
          r.cnt = vecs[i].cnt; r.last = vecs[i].last;
          src_q.push_back(r);
          for (int j = 0; j < vecs[i].exp_n; j++)
            push_exp(vecs[i].data, vecs[i].last && (j == vecs[i].exp_n - 1));
          tot = vecs[i].exp_total;
        end
      end
      run_stream(1'b0, 100);
      chk("grp_sample_cnt", sample_cnt, tot);
      chk("grp_gaps", gaps, 0);
      chk("grp_ready_block_le1", (max_blk <= 1) ? 1 : 0, 1);
    end

    // Random backpressure against a golden expansion.
    do_clr();
    for (int i = 0; i < 20; i++) begin
      r.rle  = 1'($urandom_range(0, 1));
      r.data = 8'($urandom);
      r.cnt  = 8'($urandom_range(0, 4));
      r.last = ($urandom_range(0, 3) == 0);
      src_q.push_back(r);
      for (int j = 0; j <= (r.rle ? int'(r.cnt) : 0); j++)
        push_exp(r.data, r.last && (j == (r.rle ? int'(r.cnt) : 0)));
    end
    run_stream(1'b1, 2000);
    chk("rand_sample_cnt", sample_cnt, exp_cnt);
    chk("rand_full_seen", saw_block, 1);

    // Maximum run: 256 samples without rem underflow.
    do_clr();
    r.rle = 1'b1; r.data = 8'hFF; r.cnt = 8'd255; r.last = 1'b0;
    src_q.push_back(r);
    for (int j = 0; j < 256; j++) push_exp(8'hFF, 1'b0);
    run_stream(1'b0, 400);
    chk("max_run_cnt", sample_cnt, 256);
    chk("max_run_gaps", gaps, 0);

    // CLR with active run and pending record discards both.
    do_clr();
    rle_en = 1'b1;
    tif.out_ready = 1'b0;
    tif.rec_valid = 1'b1; tif.rec_data = 8'h11; tif.rec_cnt = 8'd10; tif.rec_last = 1'b0;
    tick();
    tif.rec_data = 8'h22; tif.rec_cnt = 8'd5;
    tick();
    tif.rec_data = 8'h33;
    #1 chk("full_rec_ready", tif.rec_ready, 0);
    tick();
    tif.rec_valid = 1'b0;
    tif.out_ready = 1'b1;
    push_exp(8'h11, 1'b0);
    push_exp(8'h11, 1'b0);
    tick();
    tick();
    chk("pre_clr_cnt", sample_cnt, 2);
    do_clr();
    r.rle = 1'b1; r.data = 8'h44; r.cnt = 8'd1; r.last = 1'b1;
    src_q.push_back(r);
    push_exp(8'h44, 1'b0);
    push_exp(8'h44, 1'b1);
    run_stream(1'b0, 50);
    chk("post_clr_cnt", sample_cnt, 2);

    // Counter saturation on a 4-bit instance.
    rst4 = 1'b0;
    tif4.rec_valid = 1'b1; tif4.rec_data = 8'h5A; tif4.rec_cnt = 8'd19; tif4.rec_last = 1'b1;
    tif4.out_ready = 1'b1;
    @(negedge clk);
    tif4.rec_valid = 1'b0;
    repeat (25) @(negedge clk);
    chk("sat_sample_cnt", sample_cnt4, 15);
    chk("sat_out_valid", tif4.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
